video_ram_dp: RTL and testbench

Parametrised dual-port video RAM: the next-generation VRAM, shared between the CPU bus (port A) and the PPU fetch engine (port B). It adds synchronous one-cycle reads, a defined write-collision policy, CPU lock-out while the PPU owns VRAM (mode 3), and an optional hardware clear engine. It sits between the memory-map decoder and the PPU, replacing the fixed 8 KiB x 8 array.

---
 rtl/video_ram_pkg.sv | 16 +
 rtl/video_ram_dp_if.sv | 43 ++++
 rtl/vram_clear_fsm.sv | 58 +++++
 rtl/video_ram_dp.sv | 122 ++++++++++++
 tb/tb_video_ram_dp.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_ram_pkg.sv
// video_ram_pkg: shared defaults and clear-engine state encoding for the
// dual-port video RAM. The clear engine is built only with VRAM_CLEAR_EN.
package video_ram_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 13;

  // Value a blocked read returns at the default width (all ones).
  localparam logic [DEF_DATA_W-1:0] DEF_LOCK_DATA = '1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/video_ram_dp_if.sv
// video_ram_dp_if: CPU port (A), PPU port (B) and clear-engine signals of the
// video RAM. The master modport is the requester side, slave is the RAM.
interface video_ram_dp_if
  import video_ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              cpu_en;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  logic              ppu_lock;
  logic              ppu_en;
  logic              ppu_we;
  logic [ADDR_W-1:0] ppu_addr;
  logic [DATA_W-1:0] ppu_wdata;
  logic [DATA_W-1:0] ppu_rdata;
  logic              ppu_rvalid;

  logic              collision;
  logic              clear_start;
  logic              busy;

  modport master (
    output cpu_en, cpu_we, cpu_addr, cpu_wdata,
    output ppu_lock, ppu_en, ppu_we, ppu_addr, ppu_wdata,
    output clear_start,
    input  cpu_rdata, cpu_rvalid, ppu_rdata, ppu_rvalid, collision, busy
  );

  modport slave (
    input  cpu_en, cpu_we, cpu_addr, cpu_wdata,
    input  ppu_lock, ppu_en, ppu_we, ppu_addr, ppu_wdata,
    input  clear_start,
    output cpu_rdata, cpu_rvalid, ppu_rdata, ppu_rvalid, collision, busy
  );

endinterface

// File: rtl/vram_clear_fsm.sv
// vram_clear_fsm: walks every VRAM address once, writing zero, after each
// reset release and on clear_start while idle. While busy it owns the write
// port of the RAM. Only instantiated when VRAM_CLEAR_EN is defined.
module vram_clear_fsm
  import video_ram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear_start,
  output logic              o_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  clr_state_e        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_busy;

  // Reset parks the engine in CLEAR at address 0 so the sweep starts on release;
  // the counter wraps to 0 after the last address, ready for the next sweep.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_clear_start) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ADDR) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_clr_we   = r_busy;
  assign o_clr_addr = r_cnt;

endmodule

// File: rtl/video_ram_dp.sv
// video_ram_dp: dual-port video RAM shared by the CPU (port A) and the PPU
// fetch engine (port B). One-cycle registered reads, read-first behaviour,
// port B wins a same-address write collision, CPU locked out by ppu_lock.
// Optional hardware clear engine selected with the VRAM_CLEAR_EN macro.
module video_ram_dp
  import video_ram_pkg::*;
#(
  parameter int              DATA_W    = DEF_DATA_W,
  parameter int              ADDR_W    = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] LOCK_DATA = {DATA_W{1'b1}}
) (
  input logic           clk,
  input logic           rst,
  video_ram_dp_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_cpu_rvalid;
  logic [DATA_W-1:0] r_ppu_rdata;
  logic              r_ppu_rvalid;
  logic              r_collision;

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;

  logic w_cpu_rd;
  logic w_cpu_wr;
  logic w_ppu_rd;
  logic w_ppu_wr;
  logic w_coll;

`ifdef VRAM_CLEAR_EN
  vram_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_clear_start (bus.clear_start),
    .o_busy        (w_busy),
    .o_clr_we      (w_clr_we),
    .o_clr_addr    (w_clr_addr)
  );
`else
  logic w_unused_clear_start;

  assign w_busy               = 1'b0;
  assign w_clr_we             = 1'b0;
  assign w_clr_addr           = '0;
  assign w_unused_clear_start = bus.clear_start;
`endif

  // A clear sweep blocks both ports' writes; ppu_lock blocks only the CPU.
  assign w_cpu_rd = bus.cpu_en & ~bus.cpu_we;
  assign w_cpu_wr = bus.cpu_en & bus.cpu_we & ~bus.ppu_lock & ~w_busy;
  assign w_ppu_rd = bus.ppu_en & ~bus.ppu_we;
  assign w_ppu_wr = bus.ppu_en & bus.ppu_we & ~w_busy;
  assign w_coll   = w_cpu_wr & w_ppu_wr & (bus.cpu_addr == bus.ppu_addr);

  // Storage array: clear engine overrides both ports; port B wins a collision.
  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else begin
      if (w_cpu_wr && !w_coll) begin
        r_mem[bus.cpu_addr] <= bus.cpu_wdata;
      end
      if (w_ppu_wr) begin
        r_mem[bus.ppu_addr] <= bus.ppu_wdata;
      end
    end
  end

  // Port A read register: samples the array before this edge's writes land
  // (read-first); returns LOCK_DATA while locked out or clearing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cpu_rdata  <= '0;
      r_cpu_rvalid <= 1'b0;
    end else begin
      r_cpu_rvalid <= w_cpu_rd;
      if (w_cpu_rd) begin
        r_cpu_rdata <= (bus.ppu_lock || w_busy) ? LOCK_DATA : r_mem[bus.cpu_addr];
      end
    end
  end

  // Port B read register: read-first, blocked only by a clear sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ppu_rdata  <= '0;
      r_ppu_rvalid <= 1'b0;
    end else begin
      r_ppu_rvalid <= w_ppu_rd;
      if (w_ppu_rd) begin
        r_ppu_rdata <= w_busy ? LOCK_DATA : r_mem[bus.ppu_addr];
      end
    end
  end

  // Collision pulse, one cycle after the dropped port A write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_collision <= 1'b0;
    end else begin
      r_collision <= w_coll;
    end
  end

  assign bus.cpu_rdata  = r_cpu_rdata;
  assign bus.cpu_rvalid = r_cpu_rvalid;
  assign bus.ppu_rdata  = r_ppu_rdata;
  assign bus.ppu_rvalid = r_ppu_rvalid;
  assign bus.collision  = r_collision;
  assign bus.busy       = w_busy;

endmodule

// File: tb/tb_video_ram_dp.sv
// tb_video_ram_dp: scoreboard bench for video_ram_dp. A reference memory model
// predicts read data, latency and collision pulses at drive time; a negedge
// monitor pops and compares when the DUT produces them.
module tb_video_ram_dp;

  localparam int          DATA_W = 8;
  localparam int          ADDR_W = 11;
  localparam int          DEPTH  = 2 ** ADDR_W;
  localparam logic [7:0]  LOCK   = 8'hFF;
`ifdef VRAM_CLEAR_EN
  localparam logic        RST_BUSY = 1'b1;
`else
  localparam logic        RST_BUSY = 1'b0;
`endif

  typedef struct {
    logic [DATA_W-1:0] data;
    int                stamp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  video_ram_dp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) vif ();

  video_ram_dp #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .LOCK_DATA (LOCK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int clr_left = 0;

  exp_t cpu_q[$];
  exp_t ppu_q[$];
  int   coll_q[$];
  exp_t mon_e;

  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] last_cpu = '0;
  logic [DATA_W-1:0] last_ppu = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Called just after a rising edge: drives one request cycle, predicts its
  // results, then advances to just after the next rising edge.
  task automatic drive(input logic a_en, input logic a_we, input int a_addr, input int a_wd,
                       input logic b_en, input logic b_we, input int b_addr, input int b_wd,
                       input logic lock, input logic start);
    logic blk, aw, bw, co;
    logic [ADDR_W-1:0] aa, ba;
    exp_t e;
    aa  = a_addr[ADDR_W-1:0];
    ba  = b_addr[ADDR_W-1:0];
    chk("busy", {31'd0, vif.busy}, (clr_left > 0) ? 32'd1 : 32'd0);
    vif.cpu_en      = a_en;
    vif.cpu_we      = a_we;
    vif.cpu_addr    = aa;
    vif.cpu_wdata   = a_wd[DATA_W-1:0];
    vif.ppu_en      = b_en;
    vif.ppu_we      = b_we;
    vif.ppu_addr    = ba;
    vif.ppu_wdata   = b_wd[DATA_W-1:0];
    vif.ppu_lock    = lock;
    vif.clear_start = start;
    blk = (clr_left > 0);
    aw  = a_en & a_we & ~lock & ~blk;
    bw  = b_en & b_we & ~blk;
    co  = aw & bw & (aa == ba);
    if (a_en && !a_we) begin
      e.data  = (lock || blk) ? LOCK : model[aa];
      e.stamp = cyc + 1;
      cpu_q.push_back(e);
    end
    if (b_en && !b_we) begin
      e.data  = blk ? LOCK : model[ba];
      e.stamp = cyc + 1;
      ppu_q.push_back(e);
    end
    if (aw && !co) model[aa] = a_wd[DATA_W-1:0];
    if (bw)        model[ba] = b_wd[DATA_W-1:0];
    if (co)        coll_q.push_back(cyc + 1);
    if (clr_left > 0) clr_left--;
`ifdef VRAM_CLEAR_EN
    else if (start) begin
      clr_left = DEPTH;
      foreach (model[i]) model[i] = '0;
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr_a(input int addr, input int d);
    drive(1, 1, addr, d, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd_a(input int addr);
    drive(1, 0, addr, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_clear();
    while (clr_left > 0) idle();
  endtask

  task automatic do_reset(input int n);
    vif.cpu_en = 0; vif.cpu_we = 0; vif.cpu_addr = '0; vif.cpu_wdata = '0;
    vif.ppu_en = 0; vif.ppu_we = 0; vif.ppu_addr = '0; vif.ppu_wdata = '0;
    vif.ppu_lock = 0; vif.clear_start = 0;
    rst = 1'b1;
    cpu_q.delete(); ppu_q.delete(); coll_q.delete();
    last_cpu = '0; last_ppu = '0;
    repeat (n) begin @(posedge clk); #1; end
    chk("rst_cpu_rdata",  {24'd0, vif.cpu_rdata},  32'd0);
    chk("rst_cpu_rvalid", {31'd0, vif.cpu_rvalid}, 32'd0);
    chk("rst_ppu_rdata",  {24'd0, vif.ppu_rdata},  32'd0);
    chk("rst_ppu_rvalid", {31'd0, vif.ppu_rvalid}, 32'd0);
    chk("rst_collision",  {31'd0, vif.collision},  32'd0);
    chk("rst_busy",       {31'd0, vif.busy},       {31'd0, RST_BUSY});
    rst = 1'b0;
    clr_left = RST_BUSY ? DEPTH : 0;
`ifdef VRAM_CLEAR_EN
    foreach (model[i]) model[i] = '0;
`endif
  endtask

  // Scoreboard monitor: compares outputs away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (vif.cpu_rvalid) begin
        if (cpu_q.size() == 0) begin
          chk("cpu_spurious_rvalid", {31'd0, vif.cpu_rvalid}, 32'd0);
        end else begin
          mon_e = cpu_q.pop_front();
          chk("cpu_rdata",   {24'd0, vif.cpu_rdata}, {24'd0, mon_e.data});
          chk("cpu_latency", cyc, mon_e.stamp);
        end
        last_cpu = vif.cpu_rdata;
      end else begin
        chk("cpu_rdata_hold", {24'd0, vif.cpu_rdata}, {24'd0, last_cpu});
      end
      if (vif.ppu_rvalid) begin
        if (ppu_q.size() == 0) begin
          chk("ppu_spurious_rvalid", {31'd0, vif.ppu_rvalid}, 32'd0);
        end else begin
          mon_e = ppu_q.pop_front();
          chk("ppu_rdata",   {24'd0, vif.ppu_rdata}, {24'd0, mon_e.data});
          chk("ppu_latency", cyc, mon_e.stamp);
        end
        last_ppu = vif.ppu_rdata;
      end else begin
        chk("ppu_rdata_hold", {24'd0, vif.ppu_rdata}, {24'd0, last_ppu});
      end
      if (vif.collision) begin
        if (coll_q.size() == 0) chk("collision_spurious", {31'd0, vif.collision}, 32'd0);
        else                    chk("collision_cycle", cyc, coll_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset(3);
    wait_clear();

    // Basic write then read, plus a port B read of the same word.
    wr_a('h100, 'h5A);
    rd_a('h100);
    drive(0, 0, 0, 0, 1, 0, 'h100, 0, 0, 0);

    // Same-address write collision: port B data kept, one collision pulse.
    drive(1, 1, 'h200, 'h11, 1, 1, 'h200, 'h22, 0, 0);
    idle();
    drive(1, 0, 'h200, 0, 1, 0, 'h200, 0, 0, 0);

    // CPU lock-out: write ignored, read returns LOCK, port B unaffected.
    wr_a('h300, 'h44);
    drive(1, 1, 'h300, 'h33, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 'h300, 0, 1, 0, 'h300, 0, 1, 0);
    drive(1, 1, 'h310, 'h55, 1, 1, 'h310, 'h66, 1, 0);
    rd_a('h300);
    rd_a('h310);

    // Cross-port read-during-write is read-first in both directions.
    wr_a('h400, 'h01);
    drive(1, 0, 'h400, 0, 1, 1, 'h400, 'h02, 0, 0);
    rd_a('h400);
    wr_a('h500, 'h10);
    drive(1, 1, 'h500, 'h20, 1, 0, 'h500, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 'h500, 0, 0, 0);

    // Back-to-back reads, one per cycle on both ports.
    drive(1, 0, 'h100, 0, 1, 0, 'h400, 0, 0, 0);
    drive(1, 0, 'h200, 0, 1, 0, 'h300, 0, 0, 0);
    drive(1, 0, 'h300, 0, 1, 0, 'h200, 0, 0, 0);
    drive(1, 0, 'h400, 0, 1, 0, 'h100, 0, 0, 0);

    // Random traffic over a small address window.
    for (int i = 0; i < 8; i++) drive(1, 1, 'h10 + i, 'hC0 + i, 1, 1, 'h18 + i, 'hD0 + i, 0, 0);
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), 'h10 + $urandom_range(0, 7),
            $urandom_range(0, 255),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 1), 'h10 + $urandom_range(0, 7),
            $urandom_range(0, 255),
            ($urandom_range(0, 3) == 0), 0);
    end

`ifdef VRAM_CLEAR_EN
    // Fill, clear, probe during busy, then verify every word is zero.
    for (int a = 0; a < DEPTH; a++) wr_a(a, 'hAA);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 'h005, 0, 1, 0, 'h006, 0, 0, 0);
    drive(1, 1, 'h003, 'h55, 1, 1, 'h004, 'h66, 0, 0);
    drive(1, 1, 'h007, 'h55, 1, 1, 'h007, 'h66, 0, 1);
    drive(1, 0, 'h003, 0, 1, 0, 'h004, 0, 0, 0);
    wait_clear();
    for (int a = 0; a < DEPTH; a += 2) drive(1, 0, a, 0, 1, 0, a + 1, 0, 0, 0);

    // Reset in the middle of a sweep restarts the full sweep.
    for (int a = 0; a < 16; a++) wr_a(a, 'hAA);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (7) idle();
    do_reset(2);
    drive(1, 0, 'h007, 0, 1, 0, 'h008, 0, 0, 0);
    wait_clear();
    for (int a = 0; a < 16; a += 2) drive(1, 0, a, 0, 1, 0, a + 1, 0, 0, 0);
`else
    // clear_start has no effect without the clear engine.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    idle();
    rd_a('h100);
`endif

    repeat (3) idle();
    chk("cpu_q_drained",  cpu_q.size(),  32'd0);
    chk("ppu_q_drained",  ppu_q.size(),  32'd0);
    chk("coll_q_drained", coll_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
